// File: rtl/rd_fifo_checker.sv
// rd_fifo_checker: drains a first-word-fall-through receive FIFO and checks
// the bytes against the alternating 0xAA/0x55 test pattern.
//
// Optional feature (macro CHK_RELOCK_EN): drop lock after LOSS_THRESH
// consecutive mismatches and hunt for the pattern again.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : checker enable (0 = no reads)
//   clear      : synchronous clear of counters and state
//   empty, din : FIFO empty flag and head byte (valid while empty=0)
//   rd_en      : FIFO pop strobe (combinational from active/en/empty)
//   locked     : aligned to the pattern
//   err_pulse  : one-cycle pulse per mismatching byte
//   err_cnt    : saturating mismatch count
//   byte_cnt   : saturating accepted-byte count
module rd_fifo_checker #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             empty,
    input  logic [7:0]       din,
    output logic             rd_en,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam logic [7:0] PAT_A = 8'hAA;
    localparam logic [7:0] PAT_B = 8'h55;

    // A zero threshold would make relock meaningless.
    if (LOSS_THRESH < 1) begin : g_thresh_chk
        $error("LOSS_THRESH must be at least 1");
    end

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             active_q;
    logic [7:0]       expect_q, expect_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             err_pulse_q, err_pulse_d;

`ifdef CHK_RELOCK_EN
    localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);
    logic [MISS_W-1:0] miss_q, miss_d;
`endif

    // Reads start only once the first edge after reset release has passed.
    assign rd_en = active_q & en & ~empty;

    assign locked    = (state_q == ST_CHECK);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign byte_cnt  = byte_cnt_q;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            active_q    <= 1'b0;
            expect_q    <= PAT_A;
            err_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
`ifdef CHK_RELOCK_EN
            miss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            active_q    <= 1'b1;
            expect_q    <= expect_d;
            err_cnt_q   <= err_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            err_pulse_q <= err_pulse_d;
`ifdef CHK_RELOCK_EN
            miss_q      <= miss_d;
`endif
        end
    end

    // Next-state: clear wins and discards any byte popped in the same cycle.
    always_comb begin
        state_d     = state_q;
        expect_d    = expect_q;
        err_cnt_d   = err_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_pulse_d = 1'b0;
`ifdef CHK_RELOCK_EN
        miss_d      = miss_q;
`endif
        if (clear) begin
            state_d    = ST_HUNT;
            expect_d   = PAT_A;
            err_cnt_d  = '0;
            byte_cnt_d = '0;
`ifdef CHK_RELOCK_EN
            miss_d     = '0;
`endif
        end else if (rd_en) begin
            if (byte_cnt_q != '1) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_HUNT: begin
                    if (din == PAT_A || din == PAT_B) begin
                        state_d  = ST_CHECK;
                        expect_d = ~din;
                    end
                end
                ST_CHECK: begin
                    expect_d = ~expect_q;
                    if (din != expect_q) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
`ifdef CHK_RELOCK_EN
                        if (miss_q == MISS_W'(LOSS_THRESH - 1)) begin
                            state_d = ST_HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end else begin
                        miss_d = '0;
`endif
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_fifo_checker.sv
// Directed, table-driven bench for rd_fifo_checker.
module tb_rd_fifo_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic        empty;
    logic [7:0]  din;
    logic        rd_en;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] byte_cnt;

    int checks = 0;
    int errors = 0;

    rd_fifo_checker #(.CNT_W(32), .ERR_W(16), .LOSS_THRESH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clear     (clear),
        .empty     (empty),
        .din       (din),
        .rd_en     (rd_en),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       clr;
        logic       emp;
        logic [7:0] d;
        logic       rd;   // rd_en expected during the cycle
        logic       lk;   // outputs expected after the edge
        logic       ep;
        int         ec;
        int         bc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en_i, input logic clr_i, input logic emp_i,
                       input logic [7:0] d_i, input logic rd_i, input logic lk_i,
                       input logic ep_i, input int ec_i, input int bc_i);
        vec_t v;
        v.en = en_i; v.clr = clr_i; v.emp = emp_i; v.d = d_i; v.rd = rd_i;
        v.lk = lk_i; v.ep = ep_i; v.ec = ec_i; v.bc = bc_i;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic lk, input logic ep,
                              input int ec, input int bc);
        check({tag, " locked"},    64'(locked),    64'(lk));
        check({tag, " err_pulse"}, 64'(err_pulse), 64'(ep));
        check({tag, " err_cnt"},   64'(err_cnt),   64'(ec));
        check({tag, " byte_cnt"},  64'(byte_cnt),  64'(bc));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; clear = 1'b0; empty = 1'b1; din = 8'h00;

        // Empty FIFO after reset: nothing read, nothing locks.
        for (int i = 0; i < 3; i++) add(1, 0, 1, 8'hAA, 0, 0, 0, 0, 0);
        // Hunt past 0x13, lock on 0xAA.
        add(1, 0, 0, 8'h13, 1, 0, 0, 0, 1);
        add(1, 0, 0, 8'hAA, 1, 1, 0, 0, 2);
        add(1, 0, 0, 8'h55, 1, 1, 0, 0, 3);
        add(1, 0, 0, 8'hAA, 1, 1, 0, 0, 4);
        add(1, 0, 0, 8'h55, 1, 1, 0, 0, 5);
        // One corrupt byte, single pulse, then matching again.
        add(1, 0, 0, 8'hAA, 1, 1, 0, 0, 6);
        add(1, 0, 0, 8'h55, 1, 1, 0, 0, 7);
        add(1, 0, 0, 8'h00, 1, 1, 1, 1, 8);
        add(1, 0, 0, 8'h55, 1, 1, 0, 1, 9);
        // Gaps: empty toggling with junk on din, then en=0 for 10 cycles.
        add(1, 0, 1, 8'h00, 0, 1, 0, 1, 9);
        add(1, 0, 0, 8'hAA, 1, 1, 0, 1, 10);
        add(1, 0, 1, 8'h13, 0, 1, 0, 1, 10);
        add(1, 0, 0, 8'h55, 1, 1, 0, 1, 11);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h13, 0, 1, 0, 1, 11);
        add(1, 0, 0, 8'hAA, 1, 1, 0, 1, 12);
        // Clear coincides with a pop of 0x55: byte discarded, all cleared.
        add(1, 1, 0, 8'h55, 1, 0, 0, 0, 0);
        add(1, 0, 0, 8'h55, 1, 1, 0, 0, 1);
        add(1, 0, 0, 8'hAA, 1, 1, 0, 0, 2);
        // Four consecutive mismatches (expect 0x55, 0xAA, 0x55, 0xAA).
        add(1, 0, 0, 8'h00, 1, 1, 1, 1, 3);
        add(1, 0, 0, 8'h00, 1, 1, 1, 2, 4);
        add(1, 0, 0, 8'h00, 1, 1, 1, 3, 5);
`ifdef CHK_RELOCK_EN
        add(1, 0, 0, 8'h00, 1, 0, 1, 4, 6);
`else
        add(1, 0, 0, 8'h00, 1, 1, 1, 4, 6);
`endif
        // 0x55 relocks (or simply matches when still locked).
        add(1, 0, 0, 8'h55, 1, 1, 0, 4, 7);
        add(1, 0, 0, 8'hAA, 1, 1, 0, 4, 8);

        #12;
        check("reset rd_en", 64'(rd_en), 64'(0));
        check_outs("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            en = vecs[i].en; clear = vecs[i].clr; empty = vecs[i].emp; din = vecs[i].d;
            #1;
            check($sformatf("v%0d rd_en", i), 64'(rd_en), 64'(vecs[i].rd));
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].lk, vecs[i].ep, vecs[i].ec, vecs[i].bc);
        end

        // Reset mid-stream: immediate return to reset values.
        @(negedge clk);
        en = 1'b1; clear = 1'b0; empty = 1'b0; din = 8'h55;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst rd_en", 64'(rd_en), 64'(0));
        check_outs("midrst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel rd_en first", 64'(rd_en), 64'(0));
        @(posedge clk);
        #1;
        check_outs("rel first", 0, 0, 0, 0);
        check("rel rd_en second", 64'(rd_en), 64'(1));
        @(posedge clk);
        #1;
        check_outs("rel second", 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_fifo_checker.md
Name: rd_fifo_checker

Overview:
- Read-side counterpart of the USB FIFO test-pattern generator: drains bytes from the USB driver's receive FIFO and checks them against the alternating 0xAA/0x55 pattern.
- Locks to the pattern, counts accepted bytes and mismatches, and flags each error.
- Sits between the USB driver read FIFO (first-word-fall-through) and debug status registers/LEDs.

Parameters:
- CNT_W, 32: width of byte_cnt; saturating.
- ERR_W, 16: width of err_cnt; saturating.
- LOSS_THRESH, 4: consecutive mismatches that force relock; used only with CHK_RELOCK_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  checker enable; 0 = no reads.
- clear  input  1  synchronous clear of counters and state.
- empty  input  1  read FIFO empty.
- din  input  8  FIFO head byte; valid whenever empty=0 (FWFT).
- rd_en  output  1  FIFO pop strobe.
- locked  output  1  checker aligned to pattern.
- err_pulse  output  1  one-cycle pulse per mismatching byte.
- err_cnt  output  ERR_W  mismatch count.
- byte_cnt  output  CNT_W  accepted byte count.

Behaviour:
- Reset (rst_n=0, async): rd_en=0, locked=0, err_pulse=0, err_cnt=0, byte_cnt=0, state=HUNT, internal active=0, expect=0xAA.
- active is set on the first clk edge after rst_n deasserts.
- rd_en = active & en & ~empty, combinational. A byte is accepted on every edge where rd_en=1. No read is ever issued while empty=1.
- byte_cnt increments on every accepted byte in any state and saturates at all-ones.
- HUNT state, locked=0:
  - Accepted byte of 0xAA or 0x55: go to CHECK, expect <= ~din.
  - Any other byte: stay in HUNT; not an error.
- CHECK state, locked=1:
  - Every accepted byte is compared with expect, then expect <= ~expect regardless of the result.
  - Mismatch: err_cnt+1 (saturating at all-ones); err_pulse=1 on the following cycle only.
- Latency: locked, counters and err_pulse are registered and update on the edge that accepts the byte, so they are visible the cycle after rd_en=1.
- Gaps (empty=1 or en=0) do not disturb expect or state; checking resumes seamlessly.
- clear=1:
  - Next edge: counters=0, err_pulse=0, state=HUNT, locked=0, expect=0xAA.
  - rd_en is still driven, so a byte popped that cycle is discarded: not counted, not checked. clear has priority.
- Without relock, CHECK persists until clear or reset.
- Reset mid-stream: everything returns to reset values immediately; no partial count survives.

Optional Feature:
- Macro: CHK_RELOCK_EN.
- Defined:
  - An internal consecutive-mismatch counter increments on each mismatch and resets to 0 on each match.
  - When a mismatch makes it equal LOSS_THRESH: state goes to HUNT, locked=0, and the counter resets. That byte still increments err_cnt and raises err_pulse.
  - Bytes accepted in HUNT are never counted as errors.
- Not defined: no consecutive counter is built; CHECK is left only via clear or reset.

Test Plan:
- Reset release, empty=1, en=1 -> rd_en stays 0, all outputs 0, locked=0 indefinitely.
- FIFO supplies 0x13, 0xAA, 0x55, 0xAA, 0x55 back-to-back -> locked=1 after the 0xAA; byte_cnt=5, err_cnt=0, no err_pulse.
- Locked stream 0xAA, 0x55, 0x00, 0x55 (third byte corrupt) -> exactly one err_pulse, the cycle after 0x00 is popped; err_cnt=1; the following 0x55 matches.
- empty toggling every other cycle plus en=0 for 10 cycles mid-stream -> rd_en never asserts with empty=1; no errors; byte_cnt equals bytes popped.
- clear asserted on the same cycle as a pop of 0x55 -> byte_cnt=0, err_cnt=0, locked=0 next cycle; the popped byte is not counted.
- CHK_RELOCK_EN, LOSS_THRESH=4, locked stream then four 0x00 bytes -> err_cnt=4, locked=0 after the fourth; a subsequent 0x55 relocks.
